// File: rtl/pipe_wb_regfile.sv
// rtl/pipe_wb_regfile.sv - W-stage write-back select, 32x32 register file, commit counter
// Optional write-through bypass on the read ports: define WB_REGFILE_BYPASS_EN.
module pipe_wb_regfile (
   input  logic        clock,
   input  logic        resetn,
   input  logic        wwreg,
   input  logic        wm2reg,
   input  logic [31:0] wmo,
   input  logic [31:0] walu,
   input  logic [4:0]  wrn,
   input  logic [4:0]  rna,
   input  logic [4:0]  rnb,
   output logic [31:0] qa,
   output logic [31:0] qb,
   output logic [31:0] wdi,
   output logic [31:0] wcount
);

   logic [31:0] regs [0:31];
   logic [31:0] wcount_q;
   logic        commit;
   logic [31:0] rd_a;
   logic [31:0] rd_b;

   assign wdi    = wm2reg ? wmo : walu;
   assign commit = wwreg && (wrn != 5'd0);
   assign wcount = wcount_q;

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
         wcount_q <= '0;
      end else if (commit) begin
         regs[wrn] <= wdi;
         wcount_q  <= wcount_q + 32'd1;
      end
   end

   always_comb begin
      rd_a = (rna == 5'd0) ? 32'd0 : regs[rna];
      rd_b = (rnb == 5'd0) ? 32'd0 : regs[rnb];
   end

`ifdef WB_REGFILE_BYPASS_EN
   // commit implies wrn != 0, so an r0 read can never pick up the bypass.
   assign qa = (commit && (rna == wrn)) ? wdi : rd_a;
   assign qb = (commit && (rnb == wrn)) ? wdi : rd_b;
`else
   assign qa = rd_a;
   assign qb = rd_b;
`endif

endmodule

// File: tb/tb_pipe_wb_regfile.sv
// tb/tb_pipe_wb_regfile.sv - self-checking bench for pipe_wb_regfile against an array model
module tb_pipe_wb_regfile;

   logic        clock = 1'b0;
   logic        resetn;
   logic        wwreg;
   logic        wm2reg;
   logic [31:0] wmo;
   logic [31:0] walu;
   logic [4:0]  wrn;
   logic [4:0]  rna;
   logic [4:0]  rnb;
   logic [31:0] qa;
   logic [31:0] qb;
   logic [31:0] wdi;
   logic [31:0] wcount;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_reg [32];
   logic [31:0] m_cnt;

   always #5 clock = ~clock;

   pipe_wb_regfile dut (
      .clock  (clock),
      .resetn (resetn),
      .wwreg  (wwreg),
      .wm2reg (wm2reg),
      .wmo    (wmo),
      .walu   (walu),
      .wrn    (wrn),
      .rna    (rna),
      .rnb    (rnb),
      .qa     (qa),
      .qb     (qb),
      .wdi    (wdi),
      .wcount (wcount)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] rn);
      if (rn == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
      if (wwreg && wrn != 5'd0 && rn == wrn) return wm2reg ? wmo : walu;
`endif
      return m_reg[rn];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_cnt = 32'd0;
   endtask

   task automatic check_all(input string tag);
      check({tag, " wdi"}, wdi, wm2reg ? wmo : walu);
      check({tag, " qa"}, qa, exp_rd(rna));
      check({tag, " qb"}, qb, exp_rd(rnb));
      check({tag, " wcount"}, wcount, m_cnt);
   endtask

   // One pipeline cycle: drive after falling edge, check before and after the rising edge.
   task automatic cyc(input string tag, input logic w, input logic m2, input logic [31:0] mo,
                      input logic [31:0] alu, input logic [4:0] rn, input logic [4:0] a,
                      input logic [4:0] b);
      @(negedge clock);
      wwreg = w; wm2reg = m2; wmo = mo; walu = alu; wrn = rn; rna = a; rnb = b;
      #1;
      check_all({tag, " pre"});
      @(posedge clock);
      if (w && rn != 5'd0) begin
         m_reg[rn] = m2 ? mo : alu;
         m_cnt     = m_cnt + 32'd1;
      end
      #1;
      check_all({tag, " post"});
   endtask

   initial begin
      resetn = 1'b0;
      wwreg = 1'b0; wm2reg = 1'b0; wmo = '0; walu = '0; wrn = '0; rna = 5'd5; rnb = 5'd31;
      model_clear();
      #2;
      check("reset qa", qa, 32'd0);
      check("reset qb", qb, 32'd0);
      check("reset wcount", wcount, 32'd0);
      @(negedge clock);
      resetn = 1'b1;

      // Reset clears a written register immediately, and a write under reset is lost
      cyc("w r5", 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5);
      check("r5 written", qa, 32'hDEADBEEF);
      @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      check("async reset qa", qa, 32'd0);
      check("async reset wcount", wcount, 32'd0);
      model_clear();
      wwreg = 1'b1; wrn = 5'd5; walu = 32'hCAFEF00D; wm2reg = 1'b0;
      @(posedge clock);
      #1;
      check("write under reset lost", qa, 32'd0);
      @(negedge clock);
      wwreg = 1'b0;
      resetn = 1'b1;

      // Mux and commit
      cyc("mux mem", 1'b1, 1'b1, 32'h12345678, 32'hAAAAAAAA, 5'd7, 5'd7, 5'd0);
      check("r7 value", qa, 32'h12345678);
      check("count 1", wcount, 32'd1);
      cyc("mux alu", 1'b1, 1'b0, 32'h12345678, 32'hAAAAAAAA, 5'd8, 5'd8, 5'd7);
      check("r8 value", qa, 32'hAAAAAAAA);
      check("count 2", wcount, 32'd2);

      // r0 protection
      cyc("r0 write", 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
      check("r0 reads 0", qa, 32'd0);
      check("r0 no count", wcount, 32'd2);

      // Same-cycle hazard
      cyc("r3 init", 1'b1, 1'b0, 32'h0, 32'h11, 5'd3, 5'd3, 5'd3);
      @(negedge clock);
      wwreg = 1'b1; wm2reg = 1'b0; walu = 32'h22; wrn = 5'd3; rna = 5'd3; rnb = 5'd3;
      #1;
`ifdef WB_REGFILE_BYPASS_EN
      check("hazard qa pre", qa, 32'h22);
      check("hazard qb pre", qb, 32'h22);
`else
      check("hazard qa pre", qa, 32'h11);
      check("hazard qb pre", qb, 32'h11);
`endif
      @(posedge clock);
      m_reg[3] = 32'h22; m_cnt = m_cnt + 32'd1;
      #1;
      check("hazard qa post", qa, 32'h22);
      check("hazard qb post", qb, 32'h22);

      // wwreg gating
      cyc("gate", 1'b0, 1'b0, 32'h0, 32'h55, 5'd9, 5'd9, 5'd3);
      check("gate wdi", wdi, 32'h55);
      check("gate r9", qa, 32'd0);
      check("gate count", wcount, 32'd4);

      // Randomized traffic against the array model
      for (int n = 0; n < 400; n++) begin
         logic [4:0] rn;
         logic [4:0] a;
         logic [4:0] b;
         rn = 5'($urandom_range(0, 31));
         a  = ($urandom_range(0, 3) == 0) ? rn : 5'($urandom_range(0, 31));
         b  = ($urandom_range(0, 3) == 0) ? rn : 5'($urandom_range(0, 31));
         cyc("rand", 1'($urandom), 1'($urandom), $urandom, $urandom, rn, a, b);
      end

      // Counter wrap via a deposit into the counter register
      @(negedge clock);
      wwreg = 1'b0;
      force dut.wcount_q = 32'hFFFFFFFF;
      #1;
      release dut.wcount_q;
      #1;
      m_cnt = 32'hFFFFFFFF;
      check("wrap preset", wcount, 32'hFFFFFFFF);
      cyc("wrap", 1'b1, 1'b0, 32'h0, 32'h77, 5'd1, 5'd1, 5'd2);
      check("wrap to zero", wcount, 32'h00000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
